// File: rtl/sad_min_tracker.sv
// sad_min_tracker: scans the (2*RANGE)^2 candidate SADs of one macroblock in
// raster order and reports the minimum SAD together with its motion vector.
// Optional feature macro: SAD_MV_COST_EN adds an MV-length penalty
// ((|mvx|+|mvy|) << LAMBDA_SHIFT) to the compare value. best_sad always
// reports the raw SAD of the winner.
//
// state  | meaning
// IDLE   | waiting for start, sad_valid ignored
// SEARCH | accepting candidates, busy=1
// DONE   | done=1 for one cycle, best_* just loaded
module sad_min_tracker #(
  parameter int SAD_WIDTH    = 16,
  parameter int RANGE        = 8,
  parameter int MV_WIDTH     = 5,
  parameter int LAMBDA_SHIFT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       sad_valid,
  input  logic [SAD_WIDTH-1:0]       sad_in,
  output logic                       busy,
  output logic                       done,
  output logic [SAD_WIDTH-1:0]       best_sad,
  output logic signed [MV_WIDTH-1:0] best_mvx,
  output logic signed [MV_WIDTH-1:0] best_mvy
);

  localparam int CW      = $clog2(2 * RANGE);
  localparam int CV      = SAD_WIDTH + 8;
  localparam int CNT_MAX = 2 * RANGE - 1;
  localparam logic signed [MV_WIDTH-1:0] MV_MIN = MV_WIDTH'(-RANGE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                      r_state;
  logic [CW-1:0]               r_cx;
  logic [CW-1:0]               r_cy;
  logic [CV-1:0]               r_min;
  logic [SAD_WIDTH-1:0]        r_min_sad;
  logic signed [MV_WIDTH-1:0]  r_mvx;
  logic signed [MV_WIDTH-1:0]  r_mvy;
  logic                        r_busy;
  logic                        r_done;
  logic [SAD_WIDTH-1:0]        r_best_sad;
  logic signed [MV_WIDTH-1:0]  r_best_mvx;
  logic signed [MV_WIDTH-1:0]  r_best_mvy;

  logic signed [MV_WIDTH-1:0]  w_mvx;
  logic signed [MV_WIDTH-1:0]  w_mvy;
  logic [CV-1:0]               w_cmp;
  logic                        w_better;
  logic                        w_last;
  logic [CV-1:0]               w_nxt_min;
  logic [SAD_WIDTH-1:0]        w_nxt_sad;
  logic signed [MV_WIDTH-1:0]  w_nxt_mvx;
  logic signed [MV_WIDTH-1:0]  w_nxt_mvy;

  // MV of the candidate currently presented, derived from the scan counters
  assign w_mvx = MV_WIDTH'(r_cx) - MV_WIDTH'(RANGE);
  assign w_mvy = MV_WIDTH'(r_cy) - MV_WIDTH'(RANGE);

`ifdef SAD_MV_COST_EN
  logic [CW-1:0] w_absx;
  logic [CW-1:0] w_absy;
  logic [CV-1:0] w_mv_pen;

  // |mv| taken from the unsigned counters so -RANGE never overflows MV_WIDTH
  assign w_absx   = (r_cx >= CW'(RANGE)) ? (r_cx - CW'(RANGE)) : (CW'(RANGE) - r_cx);
  assign w_absy   = (r_cy >= CW'(RANGE)) ? (r_cy - CW'(RANGE)) : (CW'(RANGE) - r_cy);
  assign w_mv_pen = (CV'(w_absx) + CV'(w_absy)) << LAMBDA_SHIFT;
  assign w_cmp    = CV'(sad_in) + w_mv_pen;
`else
  logic w_unused_ls;
  assign w_unused_ls = (LAMBDA_SHIFT != 0);
  assign w_cmp       = CV'(sad_in);
`endif

  // strict less-than keeps the earliest candidate on ties
  assign w_better  = (w_cmp < r_min);
  assign w_last    = (r_cx == CW'(CNT_MAX)) && (r_cy == CW'(CNT_MAX));
  assign w_nxt_min = w_better ? w_cmp  : r_min;
  assign w_nxt_sad = w_better ? sad_in : r_min_sad;
  assign w_nxt_mvx = w_better ? w_mvx  : r_mvx;
  assign w_nxt_mvy = w_better ? w_mvy  : r_mvy;

  // sequencing FSM with running minimum, raster counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cx       <= '0;
      r_cy       <= '0;
      r_min      <= '1;
      r_min_sad  <= '0;
      r_mvx      <= '0;
      r_mvy      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_best_sad <= '0;
      r_best_mvx <= '0;
      r_best_mvy <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state   <= S_SEARCH;
            r_busy    <= 1'b1;
            r_cx      <= '0;
            r_cy      <= '0;
            r_min     <= '1;
            r_min_sad <= '0;
            r_mvx     <= MV_MIN;
            r_mvy     <= MV_MIN;
          end
        end
        S_SEARCH: begin
          if (sad_valid) begin
            r_min     <= w_nxt_min;
            r_min_sad <= w_nxt_sad;
            r_mvx     <= w_nxt_mvx;
            r_mvy     <= w_nxt_mvy;
            if (r_cx == CW'(CNT_MAX)) begin
              r_cx <= '0;
              r_cy <= (r_cy == CW'(CNT_MAX)) ? '0 : r_cy + CW'(1);
            end else begin
              r_cx <= r_cx + CW'(1);
            end
            if (w_last) begin
              r_state    <= S_DONE;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_best_sad <= w_nxt_sad;
              r_best_mvx <= w_nxt_mvx;
              r_best_mvy <= w_nxt_mvy;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign best_sad = r_best_sad;
  assign best_mvx = r_best_mvx;
  assign best_mvy = r_best_mvy;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Scoreboard bench for sad_min_tracker: a reference model computes the
// expected winner of each search, queues it at start, and the done monitor
// pops and compares it.
module tb_sad_min_tracker;

  localparam int SW = 16;
  localparam int RG = 8;
  localparam int MW = 5;
  localparam int LS = 2;
  localparam int SIDE = 2 * RG;
  localparam int N = SIDE * SIDE;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 sad_valid;
  logic [SW-1:0]        sad_in;
  logic                 busy;
  logic                 done;
  logic [SW-1:0]        best_sad;
  logic signed [MW-1:0] best_mvx;
  logic signed [MW-1:0] best_mvy;

  sad_min_tracker #(
    .SAD_WIDTH(SW), .RANGE(RG), .MV_WIDTH(MW), .LAMBDA_SHIFT(LS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sad_valid(sad_valid), .sad_in(sad_in),
    .busy(busy), .done(done), .best_sad(best_sad), .best_mvx(best_mvx), .best_mvy(best_mvy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint sad;
    longint mvx;
    longint mvy;
  } exp_t;

  exp_t        sb[$];
  exp_t        prev;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int          exp_done = 0;
  int unsigned sads[N];

  task automatic check(input string tag, input longint obs, input longint exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model();
    exp_t   e;
    longint bestc = 64'sh7fff_ffff_ffff_ffff;
    e.sad = 0; e.mvx = 0; e.mvy = 0;
    for (int i = 0; i < N; i++) begin
      longint mx = longint'(i % SIDE) - RG;
      longint my = longint'(i / SIDE) - RG;
      longint c  = longint'(sads[i]);
`ifdef SAD_MV_COST_EN
      c = c + (((mx < 0 ? -mx : mx) + (my < 0 ? -my : my)) << LS);
`endif
      if (c < bestc) begin
        bestc = c;
        e.sad = longint'(sads[i]);
        e.mvx = mx;
        e.mvy = my;
      end
    end
    return e;
  endfunction

  // done monitor: pop the oldest expected result and compare outputs
  always @(negedge clk) begin : mon
    exp_t e;
    if (done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("best_sad", longint'(best_sad), e.sad);
        check("best_mvx", longint'(best_mvx), e.mvx);
        check("best_mvy", longint'(best_mvy), e.mvy);
        prev = e;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_const(input int unsigned v);
    for (int i = 0; i < N; i++) sads[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) sads[i] = $urandom_range(100, 60000);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_done"}, longint'(done), 0);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_sad"},  longint'(best_sad), 0);
    check({tag, "_mvx"},  longint'(best_mvx), 0);
    check({tag, "_mvy"},  longint'(best_mvy), 0);
  endtask

  task automatic run_search(input bit gaps, input int start_at, input int rst_at);
    exp_t e;
    e = model();
    if (rst_at < 0) begin
      sb.push_back(e);
      exp_done++;
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("busy_in_search", longint'(busy), 1);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        sad_valid = 1'b0;
        sad_in    = '0;
        tick($urandom_range(0, 3));
      end
      if (i == rst_at) begin
        rst       = 1'b1;
        start     = 1'b1;
        sad_valid = 1'b1;
        sad_in    = '0;
        tick(1);
        rst       = 1'b0;
        start     = 1'b0;
        sad_valid = 1'b0;
        check_zero_outputs("abort");
        tick(3);
        check("abort_idle_busy", longint'(busy), 0);
        prev.sad = 0; prev.mvx = 0; prev.mvy = 0;
        return;
      end
      if (i == 128) check("best_hold_mid", longint'(best_sad), prev.sad);
      sad_valid = 1'b1;
      sad_in    = SW'(sads[i]);
      start     = (i == start_at);
      tick(1);
      sad_valid = 1'b0;
      start     = 1'b0;
    end
    check("done_latency", longint'(done), 1);
    check("busy_in_done", longint'(busy), 0);
    tick(1);
    check("done_one_cycle", longint'(done), 0);
  endtask

  initial begin
    prev.sad = 0; prev.mvx = 0; prev.mvy = 0;
    rst = 1'b1; start = 1'b0; sad_valid = 1'b0; sad_in = '0;
    tick(3);
    check_zero_outputs("reset");
    rst = 1'b0;
    tick(2);

    // single minimum at index 37 -> (-3,-6)
    fill_const(1000); sads[37] = 200;
    run_search(1'b0, -1, -1);
    tick(2);

    // all equal -> first candidate wins
    fill_const(500);
    run_search(1'b0, -1, -1);
    tick(2);

    // idle valids carrying SAD 0 must be ignored; then gapped run
    sad_valid = 1'b1; sad_in = '0;
    tick(5);
    sad_valid = 1'b0;
    check("idle_valid_busy", longint'(busy), 0);
    check("idle_valid_sad", longint'(best_sad), 500);
    fill_const(1000); sads[37] = 200;
    run_search(1'b1, -1, -1);
    tick(2);

    // start during search at candidate 100 is ignored
    fill_rand();
    run_search(1'b0, 100, -1);
    tick(2);

    // reset at candidate 150 aborts, then a fresh search completes
    fill_rand();
    run_search(1'b0, -1, 150);
    fill_rand();
    run_search(1'b1, -1, -1);
    tick(2);

    // MV-cost scenario: 98 at (-8,-8) vs 100 at (0,0)
    fill_const(1000); sads[0] = 98; sads[RG * SIDE + RG] = 100;
    run_search(1'b0, -1, -1);
    tick(2);

    // final candidate is the winner -> (7,7)
    fill_const(1000); sads[N-1] = 0;
    run_search(1'b0, -1, -1);
    tick(4);
    check("best_hold_after", longint'(best_sad), 0);
    check("best_hold_mvx", longint'(best_mvx), 7);

    check("done_count", longint'(n_done), longint'(exp_done));
    check("sb_drained", longint'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sad_min_tracker.md
SAD_MIN_TRACKER -- requirements
Module: sad_min_tracker

Interface
REQ-001 SHALL have parameter SAD_WIDTH, default 16, width of the incoming 16x16 SAD and of best_sad.
REQ-002 SHALL have parameter RANGE, default 8, search range per axis; candidate MVs span -RANGE..RANGE-1 on each axis.
REQ-003 SHALL have parameter MV_WIDTH, default 5, two's-complement width of each MV component.
REQ-004 SHALL have parameter LAMBDA_SHIFT, default 2, MV cost weight (used only with SAD_MV_COST_EN).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  single-cycle pulse that begins a new macroblock search.
REQ-008 SHALL have port sad_valid  input  1  sad_in holds the S16x16 SAD of the current candidate.
REQ-009 SHALL have port sad_in  input  SAD_WIDTH  16x16 SAD from the SAD adder stage.
REQ-010 SHALL have port busy  output  1  high while in SEARCH.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the result is valid.
REQ-012 SHALL have port best_sad  output  SAD_WIDTH  raw SAD of the winning candidate.
REQ-013 SHALL have port best_mvx  output  MV_WIDTH  signed horizontal MV of the winner.
REQ-014 SHALL have port best_mvy  output  MV_WIDTH  signed vertical MV of the winner.

Function
REQ-015 SHALL implement the FSM IDLE -> SEARCH -> DONE -> IDLE.
REQ-016 SHALL, in IDLE with start=1, enter SEARCH next cycle with running minimum = all-ones, running MV = (-RANGE,-RANGE), and scan counters cx=cy=0.
REQ-017 SHALL assign each accepted candidate the MV (cx-RANGE, cy-RANGE); cx increments first, then wraps 2*RANGE-1 -> 0 and increments cy (raster order).
REQ-018 SHALL accept a candidate only when state=SEARCH and sad_valid=1; sad_valid is ignored in IDLE and DONE; gaps between valids are allowed.
REQ-019 SHALL replace the running minimum and MV only when the candidate's compare value is strictly less than the running one; ties keep the earlier candidate.
REQ-020 SHALL, on acceptance of candidate index (2*RANGE)^2-1, enter DONE on the next cycle with the final comparison included.
REQ-021 SHALL, in DONE, drive done=1 for exactly one cycle, update best_sad/best_mvx/best_mvy from the running registers in that same cycle, then return to IDLE.
REQ-022 SHALL hold best_* stable from the done cycle until the next done; the outputs do not track intermediate minima.
REQ-023 SHALL ignore start while in SEARCH or DONE (no restart mid-search).
REQ-024 SHALL have a latency from the last sad_valid to done of 1 cycle.
REQ-025 SHALL drive busy=1 exactly when state=SEARCH.
REQ-026 SHALL use compare value = zero-extended sad_in without SAD_MV_COST_EN, with no overflow possible at SAD_WIDTH+8 internal width.

Reset
REQ-027 SHALL, while rst=1 at a clk edge, force state=IDLE, done=0, busy=0, best_sad=0, best_mvx=0, best_mvy=0, counters=0, running minimum=all-ones.
REQ-028 SHALL abort an in-progress search on rst with no done pulse; rst has priority over start and sad_valid in the same cycle.

Configuration
REQ-029 SHALL, when macro SAD_MV_COST_EN is defined, compare on cost = sad_in + ((|mvx|+|mvy|) << LAMBDA_SHIFT) computed at SAD_WIDTH+8 bits, while best_sad still reports the raw SAD of the winner.
REQ-030 SHALL, when SAD_MV_COST_EN is undefined, compare on raw SAD only and contain no MV-cost logic.

Verification
REQ-031 SHALL cover: RANGE=8, start, 256 valids with SAD=1000 except index 37=200 -> one done pulse 1 cycle after the last valid; best_sad=200, mvx=-3, mvy=-6.
REQ-032 SHALL cover: all 256 SADs = 500 -> best_sad=500, mv=(-8,-8) (first candidate wins the tie).
REQ-033 SHALL cover: valids with random gaps, and sad_valid pulses while in IDLE -> same result as the gap-free run; idle valids have no effect.
REQ-034 SHALL cover: start pulsed again at candidate 100 -> ignored; rst at candidate 150 -> no done, outputs=0, state=IDLE; a new search then completes correctly.
REQ-035 SHALL cover: with SAD_MV_COST_EN, SAD 100 at mv(0,0) and SAD 98 at mv(-8,-8) -> winner (0,0) because cost 100 < 98+64; without the macro -> winner (-8,-8), best_sad=98.
REQ-036 SHALL cover: last candidate (index 255) with SAD=0 -> best_sad=0, mv=(7,7), confirming that the final compare is included.
